// File: rtl/spi_reg_ctrl.sv
// SPI frame sequencer: command byte then data bytes mapped onto a
// single-cycle register bus, with read data and headers fed to MISO.
module spi_reg_ctrl #(
   parameter logic [7:0] C_HEADER     = 8'hA5,
   parameter int         C_RD_TIMEOUT = 15
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       ss_i,
   input  logic [7:0] s_axis_rx_tdata,
   input  logic       s_axis_rx_tvalid,
   output logic       s_axis_rx_tready,
   output logic [7:0] m_axis_tx_tdata,
   output logic       m_axis_tx_tvalid,
   input  logic       m_axis_tx_tready,
   output logic       reg_wr_en,
   output logic [6:0] reg_addr,
   output logic [7:0] reg_wr_data,
   output logic       reg_rd_en,
   input  logic [7:0] reg_rd_data,
   input  logic       reg_rd_valid,
   output logic       rd_timeout,
   output logic       rx_ovr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_REQ,
      S_RD_WAIT,
      S_RD_PUSH,
      S_RD_NEXT
   } state_t;

   localparam logic [7:0] TMO_M1 = 8'(C_RD_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [6:0] addr_q, addr_d;
   logic       wr_en_q, wr_en_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       rd_en_q, rd_en_d;
   logic       rd_tmo_q, rd_tmo_d;
   logic       rx_ovr_q, rx_ovr_d;
   logic [7:0] cnt_q, cnt_d;
   logic       hdr_pend_q, hdr_pend_d;
   logic       tx_valid_q, tx_valid_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [7:0] rd_buf_q, rd_buf_d;
   logic       push_pend_q, push_pend_d;
   logic       ss_meta_q, ss_meta_d;
   logic       ss_sync_q, ss_sync_d;
   logic       ss_prev_q, ss_prev_d;
   logic       fe_q, fe_d;

   logic       tx_free;
   logic       rd_hit;
   logic       tmo_hit;
   logic       rd_done;
   logic [7:0] rd_byte;
   logic       rd_load;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wr_en_d     = 1'b0;
      wr_data_d   = wr_data_q;
      rd_en_d     = 1'b0;
      rd_tmo_d    = 1'b0;
      rx_ovr_d    = 1'b0;
      cnt_d       = cnt_q;
      hdr_pend_d  = hdr_pend_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      rd_buf_d    = rd_buf_q;
      push_pend_d = push_pend_q;
      ss_meta_d   = ss_i;
      ss_sync_d   = ss_meta_q;
      ss_prev_d   = ss_sync_q;
      fe_d        = ss_sync_q & ~ss_prev_q;
      rd_load     = 1'b0;

      tx_free = !tx_valid_q || m_axis_tx_tready;
      rd_hit  = (state_q == S_RD_WAIT) && reg_rd_valid;
      tmo_hit = ((state_q == S_RD_REQ) || (state_q == S_RD_WAIT))
                && (cnt_q == TMO_M1);
      rd_done = rd_hit || tmo_hit;
      rd_byte = rd_hit ? reg_rd_data : 8'hFF;

      if (tx_valid_q && m_axis_tx_tready)
         tx_valid_d = 1'b0;
      // the write strobe uses the old address; step it afterwards
      if (wr_en_q)
         addr_d = addr_q + 7'd1;
      if ((state_q == S_RD_REQ) || (state_q == S_RD_WAIT))
         cnt_d = cnt_q + 8'd1;

      if (!fe_q) begin
         unique case (state_q)
            S_IDLE: begin
               if (s_axis_rx_tvalid) begin
                  addr_d = s_axis_rx_tdata[6:0];
                  if (s_axis_rx_tdata[7]) begin
                     state_d = S_RD_REQ;
                     rd_en_d = 1'b1;
                     cnt_d   = 8'd0;
                  end else begin
                     state_d = S_WR;
                  end
               end
            end
            S_WR: begin
               if (s_axis_rx_tvalid) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = s_axis_rx_tdata;
               end
            end
            S_RD_REQ, S_RD_WAIT: begin
               rx_ovr_d = s_axis_rx_tvalid;
               if (rd_done) begin
                  state_d  = S_RD_PUSH;
                  rd_tmo_d = !rd_hit;
                  rd_buf_d = rd_byte;
                  if (tx_free) begin
                     tx_valid_d = 1'b1;
                     tx_data_d  = rd_byte;
                     rd_load    = 1'b1;
                  end else begin
                     push_pend_d = 1'b1;
                  end
               end else if (state_q == S_RD_REQ) begin
                  state_d = S_RD_WAIT;
               end
            end
            S_RD_PUSH: begin
               rx_ovr_d = s_axis_rx_tvalid;
               if (push_pend_q) begin
                  if (tx_free) begin
                     tx_valid_d  = 1'b1;
                     tx_data_d   = rd_buf_q;
                     push_pend_d = 1'b0;
                     rd_load     = 1'b1;
                  end
               end else if (tx_valid_q && m_axis_tx_tready) begin
                  addr_d  = addr_q + 7'd1;
                  state_d = S_RD_NEXT;
               end
            end
            S_RD_NEXT: begin
               if (s_axis_rx_tvalid) begin
                  state_d = S_RD_REQ;
                  rd_en_d = 1'b1;
                  cnt_d   = 8'd0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         state_d     = S_IDLE;
         push_pend_d = 1'b0;
      end

      if (hdr_pend_q && tx_free && !rd_load) begin
         tx_valid_d = 1'b1;
         tx_data_d  = C_HEADER;
         hdr_pend_d = 1'b0;
      end
      // a frame end always owes the master a fresh header
      if (fe_q)
         hdr_pend_d = 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= S_IDLE;
         addr_q      <= 7'd0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= 8'd0;
         rd_en_q     <= 1'b0;
         rd_tmo_q    <= 1'b0;
         rx_ovr_q    <= 1'b0;
         cnt_q       <= 8'd0;
         hdr_pend_q  <= 1'b1;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'd0;
         rd_buf_q    <= 8'd0;
         push_pend_q <= 1'b0;
         ss_meta_q   <= 1'b1;
         ss_sync_q   <= 1'b1;
         ss_prev_q   <= 1'b1;
         fe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         rd_en_q     <= rd_en_d;
         rd_tmo_q    <= rd_tmo_d;
         rx_ovr_q    <= rx_ovr_d;
         cnt_q       <= cnt_d;
         hdr_pend_q  <= hdr_pend_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         rd_buf_q    <= rd_buf_d;
         push_pend_q <= push_pend_d;
         ss_meta_q   <= ss_meta_d;
         ss_sync_q   <= ss_sync_d;
         ss_prev_q   <= ss_prev_d;
         fe_q        <= fe_d;
      end
   end

   assign s_axis_rx_tready = 1'b1;
   assign m_axis_tx_tdata  = tx_data_q;
   assign m_axis_tx_tvalid = tx_valid_q;
   assign reg_wr_en        = wr_en_q;
   assign reg_addr         = addr_q;
   assign reg_wr_data      = wr_data_q;
   assign reg_rd_en        = rd_en_q;
   assign rd_timeout       = rd_tmo_q;
   assign rx_ovr           = rx_ovr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed scenarios plus random frames
// checked against a register-file model held in the bench.
module tb_spi_reg_ctrl;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       ss_i = 1'b1;
   logic [7:0] s_axis_rx_tdata = 8'd0;
   logic       s_axis_rx_tvalid = 1'b0;
   logic       s_axis_rx_tready;
   logic [7:0] m_axis_tx_tdata;
   logic       m_axis_tx_tvalid;
   logic       m_axis_tx_tready = 1'b0;
   logic       reg_wr_en;
   logic [6:0] reg_addr;
   logic [7:0] reg_wr_data;
   logic       reg_rd_en;
   logic [7:0] reg_rd_data = 8'd0;
   logic       reg_rd_valid = 1'b0;
   logic       rd_timeout;
   logic       rx_ovr;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int ovr_cnt = 0;
   int tmo_cnt = 0;

   logic [7:0] mem [128];

   always #5 aclk = ~aclk;

   spi_reg_ctrl #(.C_HEADER(8'hA5), .C_RD_TIMEOUT(15)) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .ss_i(ss_i),
      .s_axis_rx_tdata(s_axis_rx_tdata),
      .s_axis_rx_tvalid(s_axis_rx_tvalid),
      .s_axis_rx_tready(s_axis_rx_tready),
      .m_axis_tx_tdata(m_axis_tx_tdata),
      .m_axis_tx_tvalid(m_axis_tx_tvalid),
      .m_axis_tx_tready(m_axis_tx_tready),
      .reg_wr_en(reg_wr_en),
      .reg_addr(reg_addr),
      .reg_wr_data(reg_wr_data),
      .reg_rd_en(reg_rd_en),
      .reg_rd_data(reg_rd_data),
      .reg_rd_valid(reg_rd_valid),
      .rd_timeout(rd_timeout),
      .rx_ovr(rx_ovr)
   );

   always @(negedge aclk) begin
      if (reg_wr_en)  wr_cnt++;
      if (rx_ovr)     ovr_cnt++;
      if (rd_timeout) tmo_cnt++;
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      s_axis_rx_tdata  = b;
      s_axis_rx_tvalid = 1'b1;
      step();
      s_axis_rx_tvalid = 1'b0;
   endtask

   task automatic bus_respond(input int lat, input logic [7:0] d);
      repeat (lat) step();
      reg_rd_valid = 1'b1;
      reg_rd_data  = d;
      step();
      reg_rd_valid = 1'b0;
   endtask

   task automatic accept();
      m_axis_tx_tready = 1'b1;
      step();
      m_axis_tx_tready = 1'b0;
   endtask

   task automatic start_frame();
      ss_i = 1'b0;
      repeat (4) step();
   endtask

   task automatic end_frame();
      int k;
      ss_i = 1'b1;
      k = 0;
      while (k < 12 && !m_axis_tx_tvalid) begin
         step();
         k++;
      end
      checks++;
      if (m_axis_tx_tvalid !== 1'b1 || m_axis_tx_tdata !== 8'hA5) begin
         errors++;
         $display("FAIL end_frame_header: valid=%b data=%h want valid=1 data=a5",
                  m_axis_tx_tvalid, m_axis_tx_tdata);
      end
      accept();
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) step();
      checks++;
      if (m_axis_tx_tvalid !== 1'b0 || m_axis_tx_tdata !== 8'h00 ||
          reg_wr_en !== 1'b0 || reg_rd_en !== 1'b0 || reg_addr !== 7'd0 ||
          rd_timeout !== 1'b0 || rx_ovr !== 1'b0 || s_axis_rx_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: txv=%b txd=%h wr=%b rd=%b addr=%h to=%b ovr=%b rdy=%b",
                  m_axis_tx_tvalid, m_axis_tx_tdata, reg_wr_en, reg_rd_en,
                  reg_addr, rd_timeout, rx_ovr, s_axis_rx_tready);
      end
      aresetn = 1'b1;
      step();
      checks++;
      if (m_axis_tx_tvalid !== 1'b1 || m_axis_tx_tdata !== 8'hA5) begin
         errors++;
         $display("FAIL reset_header: valid=%b data=%h want 1/a5",
                  m_axis_tx_tvalid, m_axis_tx_tdata);
      end
      repeat (3) step();
      checks++;
      if (m_axis_tx_tvalid !== 1'b1 || m_axis_tx_tdata !== 8'hA5) begin
         errors++;
         $display("FAIL header_hold: valid=%b data=%h want 1/a5",
                  m_axis_tx_tvalid, m_axis_tx_tdata);
      end
      accept();
      checks++;
      if (m_axis_tx_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL header_accept: valid=%b want 0", m_axis_tx_tvalid);
      end
   endtask

   task automatic test_write_burst();
      int w0;
      start_frame();
      w0 = wr_cnt;
      send(8'h05);
      step();
      send(8'h11);
      checks++;
      if (reg_wr_en !== 1'b1 || reg_addr !== 7'h05 || reg_wr_data !== 8'h11) begin
         errors++;
         $display("FAIL write0: en=%b addr=%h data=%h want 1/05/11",
                  reg_wr_en, reg_addr, reg_wr_data);
      end
      step();
      send(8'h22);
      checks++;
      if (reg_wr_en !== 1'b1 || reg_addr !== 7'h06 || reg_wr_data !== 8'h22) begin
         errors++;
         $display("FAIL write1: en=%b addr=%h data=%h want 1/06/22",
                  reg_wr_en, reg_addr, reg_wr_data);
      end
      step();
      checks++;
      if (wr_cnt - w0 != 2) begin
         errors++;
         $display("FAIL write_count: got %0d want 2", wr_cnt - w0);
      end
      end_frame();
   endtask

   task automatic test_read_wrap();
      start_frame();
      send(8'hFF);
      checks++;
      if (reg_rd_en !== 1'b1 || reg_addr !== 7'h7F) begin
         errors++;
         $display("FAIL wrap_rd0: en=%b addr=%h want 1/7f", reg_rd_en, reg_addr);
      end
      bus_respond(3, 8'h3C);
      checks++;
      if (m_axis_tx_tvalid !== 1'b1 || m_axis_tx_tdata !== 8'h3C) begin
         errors++;
         $display("FAIL wrap_tx0: valid=%b data=%h want 1/3c",
                  m_axis_tx_tvalid, m_axis_tx_tdata);
      end
      accept();
      send(8'h00);
      checks++;
      if (reg_rd_en !== 1'b1 || reg_addr !== 7'h00) begin
         errors++;
         $display("FAIL wrap_rd1: en=%b addr=%h want 1/00", reg_rd_en, reg_addr);
      end
      bus_respond(3, 8'h4D);
      checks++;
      if (m_axis_tx_tvalid !== 1'b1 || m_axis_tx_tdata !== 8'h4D) begin
         errors++;
         $display("FAIL wrap_tx1: valid=%b data=%h want 1/4d",
                  m_axis_tx_tvalid, m_axis_tx_tdata);
      end
      accept();
      end_frame();
   endtask

   task automatic test_read_timeout();
      int t0;
      logic early;
      start_frame();
      t0 = tmo_cnt;
      early = 1'b0;
      send(8'h80);
      checks++;
      if (reg_rd_en !== 1'b1 || reg_addr !== 7'h00) begin
         errors++;
         $display("FAIL tmo_rd: en=%b addr=%h want 1/00", reg_rd_en, reg_addr);
      end
      for (int k = 1; k < 15; k++) begin
         step();
         if (m_axis_tx_tvalid || rd_timeout) early = 1'b1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL tmo_early: got early=1 want 0");
      end
      step();
      checks++;
      if (rd_timeout !== 1'b1 || m_axis_tx_tvalid !== 1'b1 ||
          m_axis_tx_tdata !== 8'hFF) begin
         errors++;
         $display("FAIL tmo_fire: to=%b valid=%b data=%h want 1/1/ff",
                  rd_timeout, m_axis_tx_tvalid, m_axis_tx_tdata);
      end
      accept();
      step();
      checks++;
      if (tmo_cnt - t0 != 1) begin
         errors++;
         $display("FAIL tmo_count: got %0d want 1", tmo_cnt - t0);
      end
      end_frame();
   endtask

   task automatic test_overrun();
      int o0;
      start_frame();
      o0 = ovr_cnt;
      send(8'h81);
      step();
      send(8'h5A);
      checks++;
      if (rx_ovr !== 1'b1) begin
         errors++;
         $display("FAIL ovr_pulse: got %b want 1", rx_ovr);
      end
      bus_respond(2, 8'hC3);
      checks++;
      if (m_axis_tx_tvalid !== 1'b1 || m_axis_tx_tdata !== 8'hC3) begin
         errors++;
         $display("FAIL ovr_tx: valid=%b data=%h want 1/c3",
                  m_axis_tx_tvalid, m_axis_tx_tdata);
      end
      accept();
      step();
      checks++;
      if (ovr_cnt - o0 != 1) begin
         errors++;
         $display("FAIL ovr_count: got %0d want 1", ovr_cnt - o0);
      end
      end_frame();
   endtask

   task automatic test_frame_abort();
      int t0;
      logic stray;
      start_frame();
      t0 = tmo_cnt;
      stray = 1'b0;
      send(8'h90);
      step();
      ss_i = 1'b1;
      repeat (4) step();
      bus_respond(0, 8'h77);
      for (int k = 0; k < 12 && !m_axis_tx_tvalid; k++) step();
      checks++;
      if (m_axis_tx_tvalid !== 1'b1 || m_axis_tx_tdata !== 8'hA5) begin
         errors++;
         $display("FAIL abort_header: valid=%b data=%h want 1/a5",
                  m_axis_tx_tvalid, m_axis_tx_tdata);
      end
      accept();
      for (int k = 0; k < 20; k++) begin
         step();
         if (m_axis_tx_tvalid) stray = 1'b1;
      end
      checks++;
      if (stray || tmo_cnt != t0) begin
         errors++;
         $display("FAIL abort_quiet: stray=%b timeouts=%0d want 0/0",
                  stray, tmo_cnt - t0);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 14; f++) begin
         int a;
         int len;
         int w0;
         logic rd;
         a   = int'($urandom_range(0, 127));
         len = int'($urandom_range(1, 4));
         rd  = 1'($urandom_range(0, 1));
         start_frame();
         if (rd) begin
            send({1'b1, 7'(a)});
            for (int i = 0; i < len; i++) begin
               int ea;
               logic [7:0] exp;
               ea = (a + i) % 128;
               if (i > 0) send(8'($urandom));
               checks++;
               if (reg_rd_en !== 1'b1 || reg_addr !== 7'(ea)) begin
                  errors++;
                  $display("FAIL rnd_rd_addr: en=%b addr=%h want 1/%h",
                           reg_rd_en, reg_addr, 7'(ea));
               end
               if ($urandom_range(0, 4) == 0) begin
                  int k;
                  exp = 8'hFF;
                  k = 0;
                  while (k < 20 && !m_axis_tx_tvalid) begin
                     step();
                     k++;
                  end
                  checks++;
                  if (k != 15 || rd_timeout !== 1'b1) begin
                     errors++;
                     $display("FAIL rnd_tmo: cycles=%0d to=%b want 15/1",
                              k, rd_timeout);
                  end
               end else begin
                  exp = mem[ea];
                  bus_respond(int'($urandom_range(1, 6)), exp);
               end
               checks++;
               if (m_axis_tx_tvalid !== 1'b1 || m_axis_tx_tdata !== exp) begin
                  errors++;
                  $display("FAIL rnd_tx: valid=%b data=%h want 1/%h",
                           m_axis_tx_tvalid, m_axis_tx_tdata, exp);
               end
               accept();
            end
         end else begin
            w0 = wr_cnt;
            send({1'b0, 7'(a)});
            step();
            for (int i = 0; i < len; i++) begin
               int ea;
               logic [7:0] d;
               ea = (a + i) % 128;
               d = 8'($urandom);
               mem[ea] = d;
               send(d);
               checks++;
               if (reg_wr_en !== 1'b1 || reg_addr !== 7'(ea) || reg_wr_data !== d) begin
                  errors++;
                  $display("FAIL rnd_wr: en=%b addr=%h data=%h want 1/%h/%h",
                           reg_wr_en, reg_addr, reg_wr_data, 7'(ea), d);
               end
               step();
            end
            checks++;
            if (wr_cnt - w0 != len) begin
               errors++;
               $display("FAIL rnd_wr_count: got %0d want %0d", wr_cnt - w0, len);
            end
         end
         end_frame();
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      test_reset();
      test_write_burst();
      test_read_wrap();
      test_read_timeout();
      test_overrun();
      test_frame_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-access controller that sequences the SPI slave datapath. It sits between the SPI slave's word-level AXI-Stream ports and a simple single-cycle register bus. It decodes each SPI frame as a command byte followed by data bytes, then issues register writes, or register reads with automatic address increment. It supplies the MISO words, either a header byte or read data, to the slave's transmit stream.

## Interface
Parameters:
- C_HEADER, 8'hA5, byte offered on transmit at reset exit and after every frame end.
- C_RD_TIMEOUT, 15, number of cycles in RD_WAIT before a read is declared failed (legal range 1..255).

Ports (clock and reset first):
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- ss_i  in  1  raw SPI slave-select (active-low), asynchronous to aclk.
- s_axis_rx_tdata  in  8  received SPI word, from the slave's axis_rx.
- s_axis_rx_tvalid  in  1  received-word valid.
- s_axis_rx_tready  out  1  tied to 1 out of reset (never back-pressures).
- m_axis_tx_tdata  out  8  next MISO word, to the slave's axis_tx.
- m_axis_tx_tvalid  out  1  transmit-word valid.
- m_axis_tx_tready  in  1  transmit-word accepted.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_addr  out  7  current register address (used for both read and write).
- reg_wr_data  out  8  write data.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  8  read data.
- reg_rd_valid  in  1  read data valid.
- rd_timeout  out  1  one-cycle pulse when a read times out.
- rx_ovr  out  1  one-cycle pulse when a received word is discarded.

## Operation
Slave-select handling:
- ss_i passes through a 2-flop synchronizer, then a registered edge detector.
- A rising edge (frame end) is acted on 3 cycles after ss_i rises.

Command byte format:
- bit7: 1 = read, 0 = write.
- bits6:0: start address.

State machine:
- **IDLE**
  - rx beat: reg_addr <= tdata[6:0].
  - tdata[7]=0 → WR; tdata[7]=1 → RD_REQ.
- **WR**
  - rx beat: reg_wr_en=1, reg_wr_data=tdata at the current reg_addr; reg_addr increments next cycle.
- **RD_REQ**
  - reg_rd_en=1 for exactly one cycle, wait counter cleared → RD_WAIT.
- **RD_WAIT**
  - reg_rd_valid → capture reg_rd_data → RD_PUSH.
  - Counter reaches C_RD_TIMEOUT with no valid → capture 8'hFF, pulse rd_timeout → RD_PUSH.
- **RD_PUSH**
  - Drive m_axis_tx_tvalid=1 with the captured byte, held until m_axis_tx_tready.
  - On accept: reg_addr++ → RD_NEXT.
- **RD_NEXT**
  - rx beat (dummy byte clocked by the master; data ignored) → RD_REQ.

Discarded words:
- An rx beat in RD_REQ, RD_WAIT or RD_PUSH is discarded and pulses rx_ovr.

Address arithmetic:
- Addresses are 7-bit and wrap from 7'h7F to 7'h00.

Frame end (synchronized ss rise), in any state:
- State → IDLE.
- Any in-flight read is abandoned; a later reg_rd_valid is ignored.
- hdr_pend is set.

Transmit register:
- Single entry. A valid word is never withdrawn: tvalid stays high and tdata stays stable until tready.
- If frame end occurs during RD_PUSH, the pending word remains valid until accepted.
- When the register is empty and hdr_pend=1, C_HEADER is loaded and hdr_pend is cleared.

Priority within one cycle:
- Frame end overrides any rx beat received in the same cycle; that beat is dropped without rx_ovr.

## Timing
Reset values (aresetn low):
- State IDLE, reg_addr=0, hdr_pend=1.
- All strobes and pulses 0.
- m_axis_tx_tvalid=0, m_axis_tx_tdata=0.
- s_axis_rx_tready=1.

Header:
- The header becomes valid on the 1st cycle after reset release.

Write latency:
- rx beat at cycle N → reg_wr_en at N+1.

Read latency:
- Command or dummy beat at cycle N → reg_rd_en at N+1.
- reg_rd_valid at cycle M → m_axis_tx_tvalid at M+1.
- Timeout: rd_timeout and the 8'hFF data are produced C_RD_TIMEOUT cycles after reg_rd_en.

Master requirement:
- Between bytes, the SPI master must leave a gap longer than the read latency plus the slave's transmit-load time.
- The controller does not detect a stale MISO word.

## Test plan
- **Reset and header:** release reset → m_axis_tx_tvalid=1, tdata=8'hA5, held until tready.
- **Write burst:** rx 8'h05, 8'h11, 8'h22 → reg_wr_en at address 5 with data 8'h11, then at address 6 with data 8'h22.
- **Read with wrap:** rx 8'hFF, reg_rd_valid after 3 cycles with data 8'h3C, then rx dummy, then data 8'h4D → tx words 8'h3C (address 7F), then 8'h4D (address 00).
- **Read timeout:** rx 8'h80 with no reg_rd_valid → rd_timeout pulses 15 cycles after reg_rd_en; tx word = 8'hFF.
- **Overrun:** rx beat arrives while in RD_WAIT → rx_ovr pulses once; the read still completes.
- **Frame abort:** ss_i rises during RD_WAIT → IDLE in 3 cycles; a later reg_rd_valid produces no tx word; the next tx word is 8'hA5.
